// File: rtl/datamover_engine_if.sv
// HWPE-Stream point-to-point interface.
// Carries one beat of data plus byte strobes with a valid/ready handshake.
// A beat transfers on a clock edge where valid and ready are both high.
//   source/master : produces valid, data, strb; consumes ready
//   sink/slave    : consumes valid, data, strb; produces ready
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/datamover_engine.sv
// Datamover stream-processing stage.
// Forwards exactly ctrl_len_i beats from data_in to data_out through a
// 2-entry elastic buffer that registers the output, and reports job progress.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous clear, same effect as reset
//   enable_i           local enable; low freezes handshakes, FSM and counters
//   ctrl_start_i       start pulse, honoured only in IDLE
//   ctrl_len_i         job length in beats, sampled on an accepted start
//   data_in            input stream (sink)
//   data_out           output stream (source)
//   flags_busy_o       high while a job is in RUN or DRAIN
//   flags_done_o       one-cycle pulse on job completion
//   flags_in_cnt_o     beats accepted in the current job
//   flags_out_cnt_o    beats emitted in the current job
module datamover_engine #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  ctrl_start_i,
  input  logic [CNT_W-1:0]      ctrl_len_i,
  hwpe_stream_intf_stream.sink   data_in,
  hwpe_stream_intf_stream.source data_out,
  output logic                  flags_busy_o,
  output logic                  flags_done_o,
  output logic [CNT_W-1:0]      flags_in_cnt_o,
  output logic [CNT_W-1:0]      flags_out_cnt_o
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] len_q,     len_d;
  logic [CNT_W-1:0] in_cnt_q,  in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [1:0]       count_q,   count_d;
  logic [DW-1:0]    dat0_q,    dat0_d;
  logic [DW-1:0]    dat1_q,    dat1_d;
  logic [SW-1:0]    strb0_q,   strb0_d;
  logic [SW-1:0]    strb1_q,   strb1_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic             pop;
  logic             push;
  logic             in_ready;

  // Slot 0 is always the head and drives data_out directly, so the output is
  // a pure register; slot 1 holds the second beat when the buffer is full.
  always_comb begin
    pop      = enable_i & (count_q != 2'd0) & data_out.ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    in_ready = enable_i & (state_q == RUN) & (in_cnt_q < len_q) &
               ((count_q != 2'd2) | pop);
    push     = data_in.valid & in_ready;

    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    count_d   = count_q;
    dat0_d    = dat0_q;
    dat1_d    = dat1_q;
    strb0_d   = strb0_q;
    strb1_d   = strb1_q;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          dat0_d  = data_in.data;
          strb0_d = data_in.strb;
        end else begin
          dat1_d  = data_in.data;
          strb1_d = data_in.strb;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        dat0_d  = dat1_q;
        strb0_d = strb1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          dat0_d  = data_in.data;
          strb0_d = data_in.strb;
        end else begin
          dat0_d  = dat1_q;
          strb0_d = strb1_q;
          dat1_d  = data_in.data;
          strb1_d = data_in.strb;
        end
      end
      default: ;
    endcase

    if (push) in_cnt_d  = in_cnt_q  + CNT_W'(1);
    if (pop)  out_cnt_d = out_cnt_q + CNT_W'(1);

    if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (ctrl_start_i) begin
            len_d     = ctrl_len_i;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = (ctrl_len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_cnt_q == len_q) state_d = DRAIN;
        end
        DRAIN: begin
          if ((out_cnt_q == len_q) && (count_q == 2'd0)) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    // Edge-detect the DONE entry so the pulse stays one cycle even if
    // enable_i holds the FSM in DONE.
    done_d = (state_d == DONE) && (state_q != DONE);

    if (clear_i) begin
      state_d   = IDLE;
      len_d     = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      count_d   = '0;
      dat0_d    = '0;
      dat1_d    = '0;
      strb0_d   = '0;
      strb1_d   = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      count_q   <= '0;
      dat0_q    <= '0;
      dat1_q    <= '0;
      strb0_q   <= '0;
      strb1_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      count_q   <= count_d;
      dat0_q    <= dat0_d;
      dat1_q    <= dat1_d;
      strb0_q   <= strb0_d;
      strb1_q   <= strb1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign data_in.ready   = in_ready;
  assign data_out.valid  = (count_q != 2'd0);
  assign data_out.data   = dat0_q;
  assign data_out.strb   = strb0_q;
  assign flags_busy_o    = busy_q;
  assign flags_done_o    = done_q;
  assign flags_in_cnt_o  = in_cnt_q;
  assign flags_out_cnt_o = out_cnt_q;

endmodule

// File: tb/tb_datamover_engine.sv
module tb_datamover_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          enable;
  logic          start;
  logic [CW-1:0] len;
  logic          busy;
  logic          done;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_s  ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_s ();

  datamover_engine #(.DW(DW), .CNT_W(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .enable_i        (enable),
    .ctrl_start_i    (start),
    .ctrl_len_i      (len),
    .data_in         (in_s),
    .data_out        (out_s),
    .flags_busy_o    (busy),
    .flags_done_o    (done),
    .flags_in_cnt_o  (in_cnt),
    .flags_out_cnt_o (out_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc;
  int pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job of L beats. Source always offers; the sink's ready follows
  // rmode (0: always, 1: pattern 1,0,0). enable_i is dropped for en_lo_len
  // cycles from en_lo_from; a stray start (len 9) is pulsed at cycle
  // start_again_at. With stop_at_acc > 0 the job is abandoned once that many
  // beats have been accepted.
  task automatic run_job(input int L, input logic [31:0] base, input int rmode,
                         input int en_lo_from, input int en_lo_len,
                         input int start_again_at, input int stop_at_acc);
    int cyc;
    int outst;
    bit exp_rdy, exp_vld, hs_in, hs_out;
    cyc = 0;
    start = 1'b1; len = CW'(L); enable = 1'b1;
    in_s.valid = 1'b1; in_s.data = base; in_s.strb = 4'h5;
    out_s.ready = 1'b0;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_cnt", 32'(in_cnt), 32'd0);
    chk("start_out_cnt", 32'(out_cnt), 32'd0);
    acc = 0; pop = 0;
    while (pop < L && cyc < 80) begin
      if (stop_at_acc > 0 && acc == stop_at_acc) break;
      enable      = !(cyc >= en_lo_from && cyc < en_lo_from + en_lo_len);
      start       = (cyc == start_again_at);
      len         = start ? CW'(9) : CW'(L);
      in_s.valid  = 1'b1;
      in_s.data   = base + 32'(acc);
      in_s.strb   = 4'(acc) ^ 4'h5;
      out_s.ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      outst   = acc - pop;
      exp_vld = outst > 0;
      exp_rdy = enable && acc < L && (outst < 2 || (outst == 2 && out_s.ready));
      chk("in_ready", 32'(in_s.ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_s.valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("out_data", out_s.data, base + 32'(pop));
        chk("out_strb", 32'(out_s.strb), 32'(4'(pop) ^ 4'h5));
      end
      hs_in  = exp_rdy;
      hs_out = exp_vld && out_s.ready && enable;
      step();
      cyc++;
      if (hs_in)  acc++;
      if (hs_out) pop++;
      chk("in_cnt", 32'(in_cnt), 32'(acc));
      chk("out_cnt", 32'(out_cnt), 32'(pop));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
    end
    start = 1'b0; len = CW'(L); enable = 1'b1;
    if (stop_at_acc == 0) begin
      chk("job_bound", 32'(pop), 32'(L));
      step();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_in_cnt", 32'(in_cnt), 32'(L));
      chk("done_out_cnt", 32'(out_cnt), 32'(L));
      chk("done_valid", 32'(out_s.valid), 32'd0);
      step();
      chk("done_end", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_s.ready), 32'd0);
      chk("idle_cnt_hold", 32'(in_cnt), 32'(L));
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; enable = 1'b0; start = 1'b0; len = '0;
    in_s.valid = 1'b0; in_s.data = '0; in_s.strb = '0; out_s.ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_s.ready), 32'd0);
    chk("rst_valid", 32'(out_s.valid), 32'd0);
    chk("rst_data", out_s.data, 32'd0);
    chk("rst_strb", 32'(out_s.strb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_cnt", 32'(in_cnt), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic job, full rate.
    run_job(4, 32'hA0, 0, 1000, 0, -1, 0);
    // Backpressure with sink ready 1,0,0,...
    run_job(8, 32'hB0, 1, 1000, 0, -1, 0);
    // Excess input: source keeps offering past len.
    run_job(3, 32'hC0, 0, 1000, 0, -1, 0);
    chk("excess_offered", 32'(in_s.valid), 32'd1);

    // len = 0: done on the next cycle, no busy, no output.
    start = 1'b1; len = '0; enable = 1'b1; in_s.valid = 1'b0;
    step();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(out_s.valid), 32'd0);
    step();
    chk("len0_done_end", 32'(done), 32'd0);

    // Stray start during RUN is ignored.
    run_job(5, 32'hD0, 0, 1000, 0, 1, 0);
    // enable low for 3 cycles mid-job with output pending.
    run_job(6, 32'hE0, 1, 2, 3, -1, 0);

    // clear after 2 accepted beats.
    run_job(6, 32'hF0, 1, 1000, 0, -1, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_s.valid = 1'b0;
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_valid", 32'(out_s.valid), 32'd0);
    chk("clr_in_cnt", 32'(in_cnt), 32'd0);
    chk("clr_out_cnt", 32'(out_cnt), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_in_ready", 32'(in_s.ready), 32'd0);
    step();
    chk("clr_no_done", 32'(done), 32'd0);
    run_job(2, 32'h50, 0, 1000, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
